// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command-side front end for the ALU datapath. Commands (opcode, a, b) are
// buffered in a small FIFO. They are issued one at a time to the datapath.
// After a fixed ALU latency the selected result is captured and returned
// over a response handshake.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_ready = !fifo_full
//   cmd_opcode, cmd_a, cmd_b   command payload
//   alu_opcode, alu_a, alu_b   registered operands/opcode to the datapath
//   alu_result                 selected datapath result, valid ALU_LATENCY
//                              edges after issue
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_opcode       captured result and the opcode that made it
//   busy                       state machine not IDLE
//   count                      FIFO occupancy
//   dbg_state                  raw state encoding (0 idle, 1 wait, 2 hold)
//
// Handshake semantics, both interfaces: a transfer happens on a rising edge
// where valid and ready are both high. A producer holds valid and payload
// stable until the transfer. cmd_ready depends only on the FIFO occupancy.
// rsp_valid does not depend combinationally on rsp_ready.
module alu_op_sequencer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OPCODE_WIDTH = 2,
  parameter int DEPTH        = 4,
  parameter int ALU_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OPCODE_WIDTH-1:0]    cmd_opcode,
  input  logic [INPUT_WIDTH-1:0]     cmd_a,
  input  logic [INPUT_WIDTH-1:0]     cmd_b,
  output logic [OPCODE_WIDTH-1:0]    alu_opcode,
  output logic [INPUT_WIDTH-1:0]     alu_a,
  output logic [INPUT_WIDTH-1:0]     alu_b,
  input  logic [INPUT_WIDTH-1:0]     alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [INPUT_WIDTH-1:0]     rsp_data,
  output logic [OPCODE_WIDTH-1:0]    rsp_opcode,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [INPUT_WIDTH-1:0]  a;
    logic [INPUT_WIDTH-1:0]  b;
  } entry_t;

  state_t                  state_q, state_d;
  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WC_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [OPCODE_WIDTH-1:0] alu_opcode_q, alu_opcode_d;
  logic [INPUT_WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [INPUT_WIDTH-1:0]  alu_b_q, alu_b_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [INPUT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [OPCODE_WIDTH-1:0] rsp_opcode_q, rsp_opcode_d;
  logic                    full;
  logic                    push;
  logic                    pop;

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wait_cnt_d   = wait_cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_opcode_d = rsp_opcode_q;
    pop          = 1'b0;

    full = (count_q == CNT_W'(DEPTH));
    push = cmd_valid && !full;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          alu_opcode_d = mem_q[rd_ptr_q].op;
          alu_a_d      = mem_q[rd_ptr_q].a;
          alu_b_d      = mem_q[rd_ptr_q].b;
          wait_cnt_d   = WC_W'(ALU_LATENCY);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - WC_W'(1);
        if (wait_cnt_q == WC_W'(1)) begin
          // alu_opcode still holds the issued opcode, so it tags the result.
          rsp_data_d   = alu_result;
          rsp_opcode_d = alu_opcode_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
    if (push) begin
      mem_d[wr_ptr_q] = '{op: cmd_opcode, a: cmd_a, b: cmd_b};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_cnt_q   <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_cnt_q   <= wait_cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_opcode_q <= rsp_opcode_d;
    end
  end

  assign cmd_ready  = !full;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_opcode = rsp_opcode_q;
  assign busy       = (state_q != S_IDLE);
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer.
// dut1 is the ALU_LATENCY=1 build. It uses a random scoreboard and
// directed checks. dut3 is the ALU_LATENCY=3 build. It covers latency and
// mid-WAIT reset. Each DUT has a behavioural datapath. That datapath drives
// the true result only during the one cycle it is architecturally valid.
// Otherwise it drives its complement, so a capture on the wrong edge shows
// up in the data.
module tb_alu_op_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- dut1 (latency 1) ----------------
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0] cmd_opcode, alu_opcode, rsp_opcode, dbg_state;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data;
  logic [2:0] count;

  alu_op_sequencer #(.INPUT_WIDTH(8), .OPCODE_WIDTH(2), .DEPTH(4), .ALU_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_opcode(rsp_opcode), .busy(busy), .count(count), .dbg_state(dbg_state)
  );

  // ---------------- dut3 (latency 3) ----------------
  logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, busy3;
  logic [1:0] cmd_opcode3, alu_opcode3, rsp_opcode3, dbg_state3;
  logic [7:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_data3;
  logic [2:0] count3;

  alu_op_sequencer #(.INPUT_WIDTH(8), .OPCODE_WIDTH(2), .DEPTH(4), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_opcode(cmd_opcode3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_opcode(rsp_opcode3), .busy(busy3), .count(count3), .dbg_state(dbg_state3)
  );

  // ---------------- reference ALU ----------------
  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return p[7:0];
    endcase
  endfunction

  // Datapath models. An issue is seen as busy rising. The result register
  // samples on the falling edge after issue. For latency 3 it then passes
  // through two more rising-edge stages.
  logic       dp1_prev = 1'b0, dp1_v = 1'b0;
  logic [7:0] dp1_d = 8'h00;
  always @(negedge clk) begin
    dp1_v    <= busy && !dp1_prev;
    dp1_d    <= alu_f(alu_opcode, alu_a, alu_b);
    dp1_prev <= busy;
  end
  assign alu_result = dp1_v ? dp1_d : ~dp1_d;

  logic       dp3_prev = 1'b0, dp3_v0 = 1'b0, dp3_v1 = 1'b0, dp3_v2 = 1'b0;
  logic [7:0] dp3_d0 = 8'h00, dp3_d1 = 8'h00, dp3_d2 = 8'h00;
  always @(negedge clk) begin
    dp3_v0   <= busy3 && !dp3_prev;
    dp3_d0   <= alu_f(alu_opcode3, alu_a3, alu_b3);
    dp3_prev <= busy3;
  end
  always @(posedge clk) begin
    dp3_v1 <= dp3_v0;
    dp3_d1 <= dp3_d0;
    dp3_v2 <= dp3_v1;
    dp3_d2 <= dp3_d1;
  end
  assign alu_result3 = dp3_v2 ? dp3_d2 : ~dp3_d2;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard / monitor (dut1) ----------------
  logic [9:0] exp_q[$];
  int         rsp_cyc_q[$];
  logic       hold_seen = 1'b0;
  logic [9:0] hold_val;

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && rsp_valid) begin
      if (hold_seen) check("rsp_stable", 32'({rsp_opcode, rsp_data}), 32'(hold_val));
      else rsp_cyc_q.push_back(cyc);
      if (rsp_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          check("rsp", 32'({rsp_opcode, rsp_data}), 32'(e));
        end
        hold_seen = 1'b0;
      end else begin
        hold_seen = 1'b1;
        hold_val  = {rsp_opcode, rsp_data};
      end
    end else begin
      hold_seen = 1'b0;
    end
  end

  // ---------------- driver tasks (dut1) ----------------
  // One offer cycle. Starts just after a rising edge and returns just after
  // the next one. acc reports whether that edge took the command.
  task automatic cmd_cycle(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output bit acc);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) exp_q.push_back({op, alu_f(op, a, b)});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int n;
    n = 0;
    do begin
      cmd_cycle(op, a, b, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    bit done_a;
    int seen;
    int n;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_opcode3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
    check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add: alu_* one edge after the push, response two edges after.
    cmd_cycle(2'd0, 8'h12, 8'h34, acc);
    check("add_accepted", 32'(acc), 32'd1);
    @(posedge clk); #1;
    check("add_alu_opcode", 32'(alu_opcode), 32'd0);
    check("add_alu_a", 32'(alu_a), 32'h12);
    check("add_alu_b", 32'(alu_b), 32'h34);
    check("add_early_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_data", 32'(rsp_data), 32'h46);
    check("add_rsp_opcode", 32'(rsp_opcode), 32'd0);
    drain();

    // Back-to-back sub/xor/mult with rsp_ready high.
    rsp_cyc_q.delete();
    send(2'd1, 8'h50, 8'h20);
    send(2'd2, 8'hF0, 8'h0F);
    send(2'd3, 8'h03, 8'h05);
    drain();
    check("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'd3);
    if (rsp_cyc_q.size() == 3) begin
      check("b2b_gap1", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd3);
      check("b2b_gap2", 32'(rsp_cyc_q[2] - rsp_cyc_q[1]), 32'd3);
    end

    // Backpressure: six offers, five taken, the sixth waits.
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'(i), 8'(8'h10 + i), 8'(8'h01 + i));
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop while IDLE with two buffered.
    rsp_ready = 1'b0;
    send(2'd0, 8'hA0, 8'h05);
    send(2'd1, 8'hA1, 8'h06);
    send(2'd2, 8'hA2, 8'h07);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) fail_now("pp_wait_timeout");
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("pp_pre_busy", 32'(busy), 32'd0);
    check("pp_pre_count", 32'(count), 32'd2);
    cmd_cycle(2'd3, 8'h0B, 8'h0C, acc);
    check("pp_accepted", 32'(acc), 32'd1);
    check("pp_post_count", 32'(count), 32'd2);
    drain();

    // Random traffic with random response backpressure (pointers wrap).
    done_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done_a = 1'b1;
      end
      begin
        while (!done_a) begin
          rsp_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain();

    // Latency-3 build: response exactly three edges after issue.
    cmd_valid3 = 1'b1; cmd_opcode3 = 2'd3; cmd_a3 = 8'h07; cmd_b3 = 8'h09;
    @(negedge clk);
    check("l3_cmd_ready", 32'(cmd_ready3), 32'd1);
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    @(posedge clk); #1;
    check("l3_issue_busy", 32'(busy3), 32'd1);
    check("l3_issue_alu", 32'({alu_opcode3, alu_a3, alu_b3}), 32'({2'd3, 8'h07, 8'h09}));
    repeat (2) begin @(posedge clk); #1; end
    check("l3_early_valid", 32'(rsp_valid3), 32'd0);
    @(posedge clk); #1;
    check("l3_rsp_valid", 32'(rsp_valid3), 32'd1);
    check("l3_rsp_data", 32'(rsp_data3), 32'h3F);
    check("l3_rsp_opcode", 32'(rsp_opcode3), 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    check("l3_back_idle", 32'(busy3), 32'd0);

    // Reset mid-WAIT with three commands queued behind the in-flight one.
    for (int i = 0; i < 4; i++) begin
      cmd_valid3 = 1'b1; cmd_opcode3 = 2'(i); cmd_a3 = 8'(8'h20 + i); cmd_b3 = 8'h03;
      @(posedge clk); #1;
    end
    cmd_valid3 = 1'b0;
    check("mr_pre_count", 32'(count3), 32'd3);
    check("mr_pre_state", 32'(dbg_state3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid3), 32'd0);
    check("mr_count", 32'(count3), 32'd0);
    check("mr_busy", 32'(busy3), 32'd0);
    check("mr_alu", 32'({alu_opcode3, alu_a3, alu_b3}), 32'd0);
    check("mr_cmd_ready", 32'(cmd_ready3), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid3 || busy3) seen++;
    end
    check("mr_no_rsp_after", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side front end for the ALU datapath. It accepts ALU commands (opcode plus two operands) over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the adder/subtractor/xor/multiplier units and the result-select register, waits the fixed datapath latency, captures the selected result, and returns it over a valid/ready response handshake. It sits between the command source and the ALU datapath: it drives `opcode` and the operands, and consumes `out_alu`.

## Interface
- `INPUT_WIDTH`, 8: operand and result width.
- `OPCODE_WIDTH`, 2: opcode width. Encoding: 00 add, 01 sub, 10 xor, 11 mult.
- `DEPTH`, 4: command FIFO entries. Must be a power of two, ≥2.
- `ALU_LATENCY`, 1: clk edges from the issue edge to the edge where `alu_result` is valid. Must be ≥1.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: FIFO can accept. Equals !full.
- `cmd_opcode`  in  OPCODE_WIDTH: command opcode.
- `cmd_a`, `cmd_b`  in  INPUT_WIDTH: command operands.
- `alu_opcode`  out  OPCODE_WIDTH: opcode to the result select.
- `alu_a`, `alu_b`  out  INPUT_WIDTH: operands to the ALU units.
- `alu_result`  in  INPUT_WIDTH: selected ALU output.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: response consumer accepts.
- `rsp_data`  out  INPUT_WIDTH: captured result.
- `rsp_opcode`  out  OPCODE_WIDTH: opcode of the command that produced `rsp_data`.
- `busy`  out  1: high when the state machine is not IDLE.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO push when `cmd_valid && cmd_ready`. A push when full is impossible because `cmd_ready` is low. Pointers wrap modulo DEPTH.
- State machine: IDLE, WAIT, HOLD.
  - IDLE, FIFO non-empty: pop the head. Register the head into `alu_opcode`/`alu_a`/`alu_b`. Load `wait_cnt` = ALU_LATENCY. Go to WAIT.
  - IDLE, FIFO empty: stay in IDLE.
  - WAIT: decrement `wait_cnt` each edge. On the edge where `wait_cnt` == 1, capture `alu_result` into `rsp_data` and `alu_opcode` into `rsp_opcode`, set `rsp_valid` = 1, and go to HOLD.
  - HOLD: `rsp_valid`, `rsp_data` and `rsp_opcode` stay stable until `rsp_ready` is sampled high. On that edge `rsp_valid` goes to 0 and the state goes to IDLE.
- `alu_*` outputs hold the last issued values until the next issue. They never glitch between operations.
- Simultaneous push and pop in the same edge are both honoured, so `count` is unchanged.
- No arithmetic is done in this block. The result width is INPUT_WIDTH, passed through exactly as presented. Any truncation (for example in the multiplier) is owned by the datapath.
- Reset, asserted at any time including mid-WAIT or mid-HOLD, takes effect immediately:
  - FIFO is emptied and pending and in-flight commands are discarded.
  - State goes to IDLE, `wait_cnt` = 0.
- Reset values: `cmd_ready` 1, `rsp_valid` 0, `rsp_data` 0, `rsp_opcode` 0, `alu_opcode` 0, `alu_a` 0, `alu_b` 0, `busy` 0, `count` 0.
- Reset release is synchronised to the design's reset scheme. The first issue can occur on the first rising edge after deassertion if the FIFO was written on that edge's preceding cycle.

## Timing
- Issue edge E (IDLE→WAIT). The datapath result register samples on the falling edge between E and E+1, so `alu_result` is valid at E+ALU_LATENCY.
- Capture at E+ALU_LATENCY. `rsp_valid` is high from that edge.
- If `rsp_ready` is held high: `rsp_valid` is high for exactly one cycle, the state returns to IDLE at E+ALU_LATENCY+1, and the next issue is at E+ALU_LATENCY+2.
  - Sustained throughput is one command per ALU_LATENCY+2 cycles.
- Command acceptance to issue latency with an empty FIFO and IDLE: push at edge P, issue at P+1.
- `cmd_ready` is combinational from `count` only. It has no path from `rsp_ready`.

## Test plan
- Reset then single add, `cmd_opcode`=00, a=0x12, b=0x34, with a behavioural ALU model at ALU_LATENCY=1:
  - `alu_*` are set one edge after the push.
  - `rsp_valid` rises two edges after the push.
  - `rsp_data`=0x46, `rsp_opcode`=00.
- Back-to-back sub/xor/mult with `rsp_ready`=1. Commands: 0x50-0x20, 0xF0^0x0F, 0x03*0x05.
  - Responses in order: 0x30, 0xFF, 0x0F.
  - Responses spaced exactly 3 cycles apart.
- Backpressure: `rsp_ready`=0, push 6 commands on consecutive edges.
  - 5 are accepted: 1 is in flight and 4 are buffered, so `count`=4 and `cmd_ready`=0.
  - The 6th is held until `rsp_ready` is raised.
  - `rsp_data` stays stable throughout the stall.
- Simultaneous push/pop with `count`=2 in IDLE: `count` stays 2 across the edge.
  - Pointer wrap check: after 10 ops, results still match the model in order.
- Reset asserted mid-WAIT with 3 commands queued:
  - Immediately: `rsp_valid`=0, `count`=0, `busy`=0, `alu_*`=0, `cmd_ready`=1.
  - No response is produced after release.
- ALU_LATENCY=3 build: the response appears exactly 3 edges after the issue edge, and the result matches the value `alu_result` held at that edge.
